alu_issue_ctrl: RTL

Drives the ALU from the decode side of the MIPS datapath.
- Accepts one instruction word plus its register operands over a valid/ready handshake.
- Decodes opcode/funct into the 3-bit ALU control code and selects opB/shamt.
- Holds the ALU inputs stable for one cycle, then captures the ALU result.
- Presents a writeback/branch record downstream over a second valid/ready handshake.

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/alu_issue_ctrl_if.sv | 54 +++++
 rtl/alu_ctrl_decode.sv | 87 ++++++++
 rtl/alu_issue_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
// Contents: ALU control codes, MIPS opcode/funct constants, FSM state encodings,
// the decoded-control struct and an immediate sign-extension helper.
// No ports (package).

package alu_ctrl_pkg;

  // 3-bit ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       use_imm;   // opB = sext(imm) instead of rt_val
    logic [4:0] dest;
    logic       wr_en;     // already cleared for dest == 0
    logic       mem_rd;
    logic       mem_wr;
    logic       is_beq;
    logic       illegal;
    logic       ovf_chk;   // add/addi/sub: subject to signed-overflow trap
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue-side, ALU-side and writeback-side signals of alu_issue_ctrl.
// Modports:
//   master - environment view: offers instructions, provides the ALU result,
//            consumes the writeback/branch record.
//   slave  - controller view (used by alu_issue_ctrl).
// Signals:
//   in_valid/in_ready, in_instr, in_rs_val, in_rt_val      instruction handshake
//   alu_opA, alu_opB, alu_shamt, alu_ctrl, alu_out, alu_carry  ALU drive/return
//   out_valid/out_ready, out_result, out_carry, out_zero, out_wr_en, out_wr_reg,
//   out_branch_taken, out_mem_rd, out_mem_wr, out_illegal, out_ovf  record handshake

interface alu_issue_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;

  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [4:0]  alu_shamt;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_carry;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic        out_wr_en;
  logic [4:0]  out_wr_reg;
  logic        out_branch_taken;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic        out_illegal;
  logic        out_ovf;

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, alu_out, alu_carry, out_ready,
    input  in_ready, alu_opA, alu_opB, alu_shamt, alu_ctrl, out_valid, out_result,
           out_carry, out_zero, out_wr_en, out_wr_reg, out_branch_taken, out_mem_rd,
           out_mem_wr, out_illegal, out_ovf
  );

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, alu_out, alu_carry, out_ready,
    output in_ready, alu_opA, alu_opB, alu_shamt, alu_ctrl, out_valid, out_result,
           out_carry, out_zero, out_wr_en, out_wr_reg, out_branch_taken, out_mem_rd,
           out_mem_wr, out_illegal, out_ovf
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decoder: instruction word -> decoded-control struct.
// Ports:
//   instr  in   32-bit instruction word
//   dec    out  decoded control (ALU code, opB select, destination, side effects)
// Unsupported opcode/funct yields an all-zero record with only 'illegal' set,
// which makes the ALU code ADD and suppresses every side effect.

module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign rt            = instr[20:16];
  assign rd            = instr[15:11];
  // rs and shamt fields are consumed by the top, not needed for decode
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.dest  = rd;
        dec.wr_en = 1'b1;
        unique case (funct)
          FN_ADD: begin
            dec.alu_ctrl = ALU_ADD;
            dec.ovf_chk  = 1'b1;
          end
          FN_SUB: begin
            dec.alu_ctrl = ALU_SUB;
            dec.ovf_chk  = 1'b1;
          end
          FN_SLL:  dec.alu_ctrl = ALU_SLL;
          FN_NOR:  dec.alu_ctrl = ALU_NOR;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          default: dec.illegal  = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.alu_ctrl = ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.dest     = rt;
        dec.wr_en    = 1'b1;
        dec.ovf_chk  = 1'b1;
      end
      OP_LW: begin
        dec.alu_ctrl = ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.dest     = rt;
        dec.wr_en    = 1'b1;
        dec.mem_rd   = 1'b1;
      end
      OP_SW: begin
        dec.alu_ctrl = ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.mem_wr   = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl = ALU_SUB;
        dec.is_beq   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end

    // $0 is hardwired: never request a write to it
    if (dec.dest == 5'd0) begin
      dec.wr_en = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts an instruction plus operands, drives the ALU for one
// cycle, captures its result and presents a writeback/branch record downstream.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   synchronous flush, drops any in-flight op (highest priority)
//   bus    slave modport of alu_issue_ctrl_if (instruction, ALU and record signals)
// Parameters: DATA_W (operand width, 32 only), REG_AW (register index width, 5).
// Optional build macro ALU_OVF_TRAP_EN: signed-overflow trap for add/addi/sub that
// raises out_ovf and suppresses the register write. Undefined: out_ovf is 0.
// Timing: accept in IDLE/RESP -> EXEC (ALU inputs held) -> RESP (out_valid).

module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  alu_issue_ctrl_if.slave bus
);

  localparam int unsigned Msb = DATA_W - 1;

  logic [1:0] state_q, state_d;
  dec_t       dec;
  logic       accept;
  logic       capture;

  logic [DATA_W-1:0] opa_d, opb_d;
  logic [4:0]        shamt_d;

  logic [DATA_W-1:0] opa_q, opb_q, result_q;
  logic [4:0]        shamt_q;
  logic [2:0]        ctrl_q;
  logic [REG_AW-1:0] dest_q;
  logic              wr_en_q, mem_rd_q, mem_wr_q, is_beq_q, illegal_q, ovf_chk_q, is_add_q;
  logic              carry_q, zero_q, ovf_q, ovf_d;

  alu_ctrl_decode u_decode (
    .instr (bus.in_instr),
    .dec   (dec)
  );

  // Flush blocks acceptance so an instruction offered alongside it is not consumed
  assign bus.in_ready = ~flush & ((state_q == IDLE) | ((state_q == RESP) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign capture      = (state_q == EXEC) & ~flush;

  // Operand selection; illegal encodings drive ADD 0 + 0
  always_comb begin
    opa_d   = '0;
    opb_d   = '0;
    shamt_d = '0;
    if (!dec.illegal) begin
      opa_d = bus.in_rs_val;
      opb_d = dec.use_imm ? sext16(bus.in_instr[15:0]) : bus.in_rt_val;
      if (bus.in_instr[31:26] == OP_RTYPE) begin
        shamt_d = bus.in_instr[10:6];
      end
    end
  end

`ifdef ALU_OVF_TRAP_EN
  // Judged on the registered operands and the ALU result being captured this cycle
  always_comb begin
    ovf_d = 1'b0;
    if (ovf_chk_q) begin
      if (ctrl_q == ALU_SUB) begin
        ovf_d = (opa_q[Msb] != opb_q[Msb]) && (bus.alu_out[Msb] != opa_q[Msb]);
      end else begin
        ovf_d = (opa_q[Msb] == opb_q[Msb]) && (bus.alu_out[Msb] != opa_q[Msb]);
      end
    end
  end
`else
  logic unused_ovf_chk;
  assign unused_ovf_chk = ovf_chk_q;
  assign ovf_d          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = EXEC;
        EXEC: state_d = RESP;
        RESP: if (bus.out_ready) state_d = accept ? EXEC : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      shamt_q   <= '0;
      ctrl_q    <= '0;
      dest_q    <= '0;
      wr_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      is_beq_q  <= 1'b0;
      illegal_q <= 1'b0;
      ovf_chk_q <= 1'b0;
      is_add_q  <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        shamt_q   <= shamt_d;
        ctrl_q    <= dec.alu_ctrl;
        dest_q    <= dec.dest;
        wr_en_q   <= dec.wr_en;
        mem_rd_q  <= dec.mem_rd;
        mem_wr_q  <= dec.mem_wr;
        is_beq_q  <= dec.is_beq;
        illegal_q <= dec.illegal;
        ovf_chk_q <= dec.ovf_chk;
        is_add_q  <= (dec.alu_ctrl == ALU_ADD) & ~dec.illegal;
      end
      if (capture) begin
        result_q <= bus.alu_out;
        carry_q  <= is_add_q & bus.alu_carry;
        // Zero is derived locally; the ALU's own zero flag is not trusted here
        zero_q   <= (bus.alu_out == '0);
        ovf_q    <= ovf_d;
      end
    end
  end

  assign bus.alu_opA          = opa_q;
  assign bus.alu_opB          = opb_q;
  assign bus.alu_shamt        = shamt_q;
  assign bus.alu_ctrl         = ctrl_q;

  assign bus.out_valid        = (state_q == RESP) & ~flush;
  assign bus.out_result       = result_q;
  assign bus.out_carry        = carry_q;
  assign bus.out_zero         = zero_q;
  assign bus.out_wr_en        = wr_en_q & ~ovf_q;
  assign bus.out_wr_reg       = dest_q;
  assign bus.out_branch_taken = is_beq_q & zero_q;
  assign bus.out_mem_rd       = mem_rd_q;
  assign bus.out_mem_wr       = mem_wr_q;
  assign bus.out_illegal      = illegal_q;
  assign bus.out_ovf          = ovf_q;

endmodule
